// File: rtl/seq_divider_frac.sv
// Radix-2 restoring divider: fixed-point quotient (FRAC_W fraction bits) plus remainder,
// one quotient bit per cycle, valid/ready on both sides. Optional macro ROUND_EN adds round-to-nearest.
module seq_divider_frac #(
  parameter  int DIVIDEND_W = 10,
  parameter  int DIVISOR_W  = 3,
  parameter  int FRAC_W     = 10,
  localparam int Q_W        = DIVIDEND_W + FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Q_W-1:0]        out_quotient,
  output logic [DIVISOR_W-1:0]  out_remainder,
  output logic                  out_dbz
);

  localparam int CNT_W = $clog2(Q_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_r;
  state_t               state_next;
  logic [DIVISOR_W-1:0] divisor_r;
  logic [DIVISOR_W-1:0] prem_r;
  logic [Q_W-1:0]       shift_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [Q_W-1:0]       quotient_r;
  logic [DIVISOR_W-1:0] remainder_r;
  logic                 dbz_r;

  logic [DIVISOR_W:0]   trial_s;
  logic                 ge_s;
  logic [DIVISOR_W-1:0] prem_next_s;
  logic [Q_W-1:0]       shift_next_s;

`ifdef ROUND_EN
  logic                 guard_phase_r;
  logic                 guard_s;
  logic [Q_W:0]         rounded_s;
  logic [Q_W-1:0]       rounded_sat_s;
`endif

  assign in_ready      = (state_r == IDLE);
  assign out_valid     = (state_r == DONE);
  assign out_quotient  = quotient_r;
  assign out_remainder = remainder_r;
  assign out_dbz       = dbz_r;

  // One restoring step: the shift register shifts dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    trial_s      = {prem_r, shift_r[Q_W-1]};
    ge_s         = (trial_s >= {1'b0, divisor_r});
    prem_next_s  = trial_s[DIVISOR_W-1:0];
    if (ge_s) begin
      prem_next_s = DIVISOR_W'(trial_s - {1'b0, divisor_r});
    end else begin
      prem_next_s = trial_s[DIVISOR_W-1:0];
    end
    shift_next_s = Q_W'({shift_r, ge_s});
  end

`ifdef ROUND_EN
  // Guard bit compares twice the final remainder against the divisor; increment saturates.
  always_comb begin
    guard_s       = ({prem_r, 1'b0} >= {1'b0, divisor_r});
    rounded_s     = {1'b0, shift_r} + (Q_W + 1)'(guard_s);
    rounded_sat_s = rounded_s[Q_W-1:0];
    if (rounded_s[Q_W]) begin
      rounded_sat_s = '1;
    end else begin
      rounded_sat_s = rounded_s[Q_W-1:0];
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips CALC entirely.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_divisor == '0) ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
`ifdef ROUND_EN
        if (guard_phase_r) begin
`else
        if (cnt_r == '0) begin
`endif
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers; results only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_r     <= '0;
      prem_r        <= '0;
      shift_r       <= '0;
      cnt_r         <= '0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      dbz_r         <= 1'b0;
`ifdef ROUND_EN
      guard_phase_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            divisor_r <= in_divisor;
            prem_r    <= '0;
            shift_r   <= Q_W'(in_dividend) << FRAC_W;
            cnt_r     <= CNT_W'(Q_W - 1);
`ifdef ROUND_EN
            guard_phase_r <= 1'b0;
`endif
            if (in_divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= '0;
              dbz_r       <= 1'b1;
            end
          end
        end
        CALC: begin
`ifdef ROUND_EN
          if (guard_phase_r) begin
            quotient_r    <= rounded_sat_s;
            remainder_r   <= prem_r;
            dbz_r         <= 1'b0;
            guard_phase_r <= 1'b0;
          end else begin
            prem_r  <= prem_next_s;
            shift_r <= shift_next_s;
            cnt_r   <= cnt_r - CNT_W'(1);
            if (cnt_r == '0) begin
              guard_phase_r <= 1'b1;
            end
          end
`else
          prem_r  <= prem_next_s;
          shift_r <= shift_next_s;
          cnt_r   <= cnt_r - CNT_W'(1);
          if (cnt_r == '0) begin
            quotient_r  <= shift_next_s;
            remainder_r <= prem_next_s;
            dbz_r       <= 1'b0;
          end
`endif
        end
        DONE: begin
          divisor_r <= divisor_r;
        end
        default: begin
          divisor_r <= divisor_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_frac.sv
// Directed self-checking bench for seq_divider_frac with default parameters.
module tb_seq_divider_frac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_dividend;
  logic [2:0]  in_divisor;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_quotient;
  logic [2:0]  out_remainder;
  logic        out_dbz;

  int total = 0;
  int bad   = 0;

`ifdef ROUND_EN
  localparam int LAT = 22;
  localparam logic [19:0] Q_2_3 = 20'd683;
`else
  localparam int LAT = 21;
  localparam logic [19:0] Q_2_3 = 20'd682;
`endif

  seq_divider_frac dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_dbz(out_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operand pair and count cycles until out_valid (1 = cycle right after accept edge).
  task automatic run_op(input logic [9:0] a, input logic [2:0] b, output int lat);
    int w;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL timeout a=%0d b=%0d: out_valid never rose within %0d cycles", a, b, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_dividend = '0; in_divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, out_quotient, out_remainder, out_dbz} !== {1'b1, 1'b0, 20'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b v=%b q=%0d r=%0d dbz=%b, want rdy=1 v=0 q=0 r=0 dbz=0",
               in_ready, out_valid, out_quotient, out_remainder, out_dbz);
    end
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [19:0] eq, input logic [2:0] er, input logic ed);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if ({out_quotient, out_remainder, out_dbz} !== {eq, er, ed}) begin
      bad++;
      $display("FAIL %s_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               name, out_quotient, out_remainder, out_dbz, eq, er, ed);
    end
    // out_ready is high here: handshake on the next edge, then IDLE.
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_handshake: got v=%b rdy=%b want v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_divide();
    int lat;
    out_ready = 1'b1;
    run_op(10'd1000, 3'd3, lat);
    check_result("div_1000_3", lat, LAT, 20'd341333, 3'd1, 1'b0);
    run_op(10'd7, 3'd7, lat);
    check_result("div_7_7", lat, LAT, 20'd1024, 3'd0, 1'b0);
    run_op(10'd1023, 3'd1, lat);
    check_result("div_1023_1", lat, LAT, 20'd1047552, 3'd0, 1'b0);
    run_op(10'd0, 3'd5, lat);
    check_result("div_0_5", lat, LAT, 20'd0, 3'd0, 1'b0);
    run_op(10'd2, 3'd3, lat);
    check_result("div_2_3", lat, LAT, Q_2_3, 3'd2, 1'b0);
  endtask

  task automatic test_dbz();
    int lat;
    out_ready = 1'b1;
    run_op(10'd5, 3'd0, lat);
    check_result("dbz", lat, 1, 20'hFFFFF, 3'd0, 1'b1);
    run_op(10'd7, 3'd7, lat);
    check_result("dbz_clear", lat, LAT, 20'd1024, 3'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable;
    out_ready = 1'b0;
    fork
      run_op(10'd1000, 3'd3, lat);
      begin
        // Competing operands pulsed while the divider is busy must be ignored.
        repeat (4) @(posedge clk);
        #2;
        in_dividend = 10'd15; in_divisor = 3'd1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b0;
      end
    join
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
    end
    unstable = 0;
    in_dividend = 10'd15; in_divisor = 3'd1;
    for (int i = 0; i < 50; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      if ({out_valid, in_ready, out_quotient, out_remainder, out_dbz} !== {1'b1, 1'b0, 20'd341333, 3'd1, 1'b0})
        unstable++;
    end
    in_valid = 1'b0;
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL bp_stall: %0d of 50 stalled cycles deviated, want 0 (q=%0d v=%b rdy=%b)",
               unstable, out_quotient, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, out_quotient, out_remainder} !== {1'b0, 1'b1, 20'd341333, 3'd1}) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b q=%0d r=%0d want v=0 rdy=1 q=341333 r=1",
               out_valid, in_ready, out_quotient, out_remainder);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    out_ready = 1'b1;
    in_dividend = 10'd1000; in_divisor = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, out_quotient, out_remainder, out_dbz} !== {1'b1, 1'b0, 20'd0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b v=%b q=%0d r=%0d dbz=%b want rdy=1 v=0 q=0 r=0 dbz=0",
               in_ready, out_valid, out_quotient, out_remainder, out_dbz);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_discard: out_valid seen %0d cycles after reset, want 0", seen);
    end
    run_op(10'd1000, 3'd3, lat);
    check_result("after_reset", lat, LAT, 20'd341333, 3'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_dbz();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_frac.md
Name: seq_divider_frac

Overview:
Parametrised radix-2 restoring divider producing an unsigned fixed-point quotient (integer plus FRAC_W fraction bits) and a remainder, one quotient bit per cycle. It is the successor of the fixed 10-bit/3-bit fractional divider, with these additions:
- generic operand widths;
- valid/ready handshakes on both sides with output backpressure;
- remainder output;
- explicit divide-by-zero handling.

It sits between an operand-capture stage and any downstream consumer that may stall.

Parameters:
DIVIDEND_W, 10, dividend width in bits (>=1)
DIVISOR_W, 3, divisor width in bits (>=1)
FRAC_W, 10, number of fractional quotient bits appended below the dividend LSB (>=0)
Q_W, DIVIDEND_W+FRAC_W, quotient width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
in_dividend  in  DIVIDEND_W  unsigned dividend
in_divisor  in  DIVISOR_W  unsigned divisor
out_valid  out  1  result present, held until accepted
out_ready  in  1  consumer accepts result
out_quotient  out  Q_W  floor((dividend<<FRAC_W)/divisor); ROUND_EN changes this, see Optional Feature
out_remainder  out  DIVISOR_W  (dividend<<FRAC_W) - truncated_quotient*divisor
out_dbz  out  1  divide-by-zero flag for current result

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_quotient=0, out_remainder=0, out_dbz=0, all internal registers 0.
- Reset mid-operation: the next edge returns to IDLE; the in-flight result is discarded and never presented.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). Combinational from the state register only.
- Accept: in_valid && in_ready at an edge latches the operands into internal registers.
- Accept with divisor != 0:
  - go to CALC;
  - iteration counter = Q_W-1;
  - partial remainder = 0;
  - shift register = {dividend, FRAC_W zeros}.
- Accept with divisor == 0:
  - go directly to DONE;
  - out_quotient = all ones;
  - out_remainder = 0;
  - out_dbz = 1;
  - result is visible one cycle after accept.
- CALC, each cycle:
  - r = {partial_rem, next MSB of shift reg}, DIVISOR_W+1 bits;
  - if r >= divisor: partial_rem = r - divisor, quotient bit = 1;
  - else: partial_rem = r[DIVISOR_W-1:0], quotient bit = 0;
  - quotient bits are shifted in MSB-first.
- CALC exit: after the cycle where counter == 0, go to DONE.
- Latency: out_valid asserts exactly Q_W+1 cycles after the accept edge (20+1 = 21 with defaults).
- DONE:
  - out_valid=1;
  - out_quotient, out_remainder and out_dbz are held stable while out_ready=0, for an unbounded stall;
  - out_valid && out_ready at an edge: go to IDLE, out_valid=0. Output data registers keep their last value.
- No back-to-back overlap: a new accept is possible only in IDLE, i.e. at the earliest one cycle after the result handshake.
- in_valid while busy: ignored, operands not sampled. The producer holds its operands until in_ready.
- Width rules:
  - internal compare and subtract are DIVISOR_W+1 bits wide;
  - the quotient cannot overflow Q_W, since divisor >= 1;
  - the remainder is always < divisor.
- in_dividend == 0: a normal CALC pass with full latency, giving quotient 0, remainder 0.

Optional Feature:
Macro ROUND_EN.
- Defined:
  - one extra CALC cycle computes guard bit g = ({partial_rem,1'b0} >= divisor), without updating partial_rem;
  - out_quotient = truncated quotient + g, saturating at all ones;
  - out_remainder still refers to the truncated quotient;
  - latency becomes Q_W+2;
  - the divide-by-zero path is unchanged.
- Undefined: truncating behaviour as described above, latency Q_W+1.

Test Plan:
- Defaults, dividend=1000, divisor=3, out_ready=1 -> out_quotient=341333, out_remainder=1, out_dbz=0, out_valid exactly 21 cycles after accept.
- Defaults, dividend=7, divisor=7 -> quotient=1024, remainder=0. Then dividend=1023, divisor=1 -> quotient=1047552, remainder=0.
- Divisor=0, dividend=5 -> out_dbz=1, quotient=20'hFFFFF, remainder=0, out_valid one cycle after accept. Next operation clears out_dbz.
- Backpressure: out_ready=0 for 50 cycles after out_valid -> outputs stable and in_ready=0. Raise out_ready: one-cycle handshake, then in_ready=1 the next cycle. in_valid pulses while busy are not captured.
- Reset asserted in the 10th CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0. A following 1000/3 gives the correct result.
- ROUND_EN, dividend=2, divisor=3 -> quotient=683, remainder=2, latency 22. Without ROUND_EN -> quotient=682, latency 21.
